// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, branch/jump target selection,
// IDLE/RUN/HALT sequencing, programmable jump LUT and saturating cycle counter.
module fetch_unit #(
    parameter int PW     = 10,
    parameter int LUT_AW = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [PW-1:0]     StartAddr,
    input  logic              BranchEn,
    input  logic              Jump,
    input  logic              BranchCond,
    input  logic [5:0]        Offset,
    input  logic              Ack,
    input  logic              LutWrEn,
    input  logic [LUT_AW-1:0] LutWrAddr,
    input  logic [PW-1:0]     LutWrData,
    output logic [PW-1:0]     ProgCtr,
    output logic              Running,
    output logic              Done,
    output logic [15:0]       CycleCount
);

    localparam int LUT_DEPTH = 2 ** LUT_AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [PW-1:0]     pc_r;
    logic [PW-1:0]     pc_nxt_s;
    logic [15:0]       cnt_r;
    logic [15:0]       cnt_nxt_s;
    logic [PW-1:0]     lut_r [LUT_DEPTH];
    logic [PW-1:0]     offset_ext_s;
    logic              taken_s;
    logic              lut_wr_s;

    assign offset_ext_s = {{(PW-6){Offset[5]}}, Offset};
    assign taken_s      = BranchEn & BranchCond;

    // State, PC and cycle counter registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            pc_r    <= {PW{1'b0}};
            cnt_r   <= 16'h0000;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Jump LUT storage; writes are locked out while a program runs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_r[i] <= {PW{1'b0}};
            end
        end else if (lut_wr_s) begin
            lut_r[LutWrAddr] <= LutWrData;
        end else begin
            lut_r[LutWrAddr] <= lut_r[LutWrAddr];
        end
    end

    // Next-state, next-PC and next-count selection
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        cnt_nxt_s   = cnt_r;
        lut_wr_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_HALT: begin
                lut_wr_s = LutWrEn;
                if (Start) begin
                    state_nxt_s = ST_RUN;
                    pc_nxt_s    = StartAddr;
                    cnt_nxt_s   = 16'h0000;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                // Counter includes the Ack cycle and sticks at all-ones
                if (cnt_r != 16'hFFFF) begin
                    cnt_nxt_s = cnt_r + 16'h0001;
                end else begin
                    cnt_nxt_s = cnt_r;
                end
                if (Ack) begin
                    state_nxt_s = ST_HALT;
                    pc_nxt_s    = pc_r;
                end else if (taken_s && Jump) begin
                    pc_nxt_s = lut_r[Offset[LUT_AW-1:0]];
                end else if (taken_s) begin
                    pc_nxt_s = pc_r + offset_ext_s;
                end else begin
                    pc_nxt_s = pc_r + PW'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                pc_nxt_s    = {PW{1'b0}};
                cnt_nxt_s   = 16'h0000;
            end
        endcase
    end

    // Status outputs decoded from the registered state
    always_comb begin
        Running = 1'b0;
        Done    = 1'b0;
        case (state_r)
            ST_RUN:  Running = 1'b1;
            ST_HALT: Done    = 1'b1;
            default: begin
                Running = 1'b0;
                Done    = 1'b0;
            end
        endcase
    end

    assign ProgCtr    = pc_r;
    assign CycleCount = cnt_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed steps plus random traffic,
// compared against an arithmetic reference model of the fetch rules.
module tb_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset, Start, BranchEn, Jump, BranchCond, Ack, LutWrEn;
    logic [9:0]  StartAddr, LutWrData, ProgCtr;
    logic [5:0]  Offset;
    logic [3:0]  LutWrAddr;
    logic        Running, Done;
    logic [15:0] CycleCount;

    int total = 0;
    int bad   = 0;

    // reference model
    bit m_run, m_done;
    int m_pc, m_cnt;
    int m_lut [16];

    fetch_unit dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .BranchEn(BranchEn), .Jump(Jump), .BranchCond(BranchCond),
        .Offset(Offset), .Ack(Ack), .LutWrEn(LutWrEn), .LutWrAddr(LutWrAddr),
        .LutWrData(LutWrData), .ProgCtr(ProgCtr), .Running(Running),
        .Done(Done), .CycleCount(CycleCount)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        int soff;
        if (Reset) begin
            m_run = 1'b0; m_done = 1'b0; m_pc = 0; m_cnt = 0;
            foreach (m_lut[i]) m_lut[i] = 0;
        end else if (!m_run) begin
            if (LutWrEn) m_lut[LutWrAddr] = LutWrData;
            if (Start) begin
                m_run = 1'b1; m_done = 1'b0; m_pc = StartAddr; m_cnt = 0;
            end
        end else begin
            m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
            soff = Offset;
            if (soff >= 32) soff -= 64;
            if (Ack) begin
                m_run = 1'b0; m_done = 1'b1;
            end else if (BranchEn && BranchCond && Jump) begin
                m_pc = m_lut[Offset % 16];
            end else if (BranchEn && BranchCond) begin
                m_pc = (m_pc + soff + 1024) % 1024;
            end else begin
                m_pc = (m_pc + 1) % 1024;
            end
        end
    endtask

    task automatic step(input bit rst, input bit st, input int sa,
                        input bit be, input bit jp, input bit bc, input int off,
                        input bit ak, input bit we, input int wa, input int wd);
        Reset = rst; Start = st; StartAddr = 10'(sa);
        BranchEn = be; Jump = jp; BranchCond = bc; Offset = 6'(off); Ack = ak;
        LutWrEn = we; LutWrAddr = 4'(wa); LutWrData = 10'(wd);
        model_update();
        @(posedge Clk);
        #1;
        chk("pc", 32'(ProgCtr), 32'(m_pc));
        chk("running", 32'(Running), 32'(m_run));
        chk("done", 32'(Done), 32'(m_done));
        chk("count", 32'(CycleCount), 32'(m_cnt));
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic br(input bit jp, input bit bc, input int off, input bit ak);
        step(0, 0, 0, 1, jp, bc, off, ak, 0, 0, 0);
    endtask

    task automatic start_at(input int sa);
        step(0, 1, sa, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        m_run = 1'b0; m_done = 1'b0; m_pc = 0; m_cnt = 0;
        foreach (m_lut[i]) m_lut[i] = 0;

        // reset state, then sequential fetch from 5
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        start_at(10'h005);
        repeat (4) nop();
        chk("seq_pc9", 32'(ProgCtr), 32'h9);
        chk("seq_cnt4", 32'(CycleCount), 32'd4);

        // relative branches around pc 20
        br(0, 1, 11, 0);            // 9 -> 20
        br(0, 1, 6'b111100, 0);     // 20 -> 16
        chk("rel_neg", 32'(ProgCtr), 32'd16);
        br(0, 1, 4, 0);             // 16 -> 20
        br(0, 0, 6'b111100, 0);     // not taken -> 21
        chk("rel_not_taken", 32'(ProgCtr), 32'd21);
        br(0, 1, 0, 0);             // self-loop

        // LUT write together with Start, then jump through LUT
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 7, 0, 0, 0, 0, 0, 1, 3, 10'h2A0);
        br(1, 1, 6'b110011, 0);
        chk("lut_jump", 32'(ProgCtr), 32'h2A0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 10'h111);   // dropped in RUN
        br(1, 1, 3, 0);
        chk("lut_locked", 32'(ProgCtr), 32'h2A0);

        // wrap at both ends
        br(0, 0, 0, 1);
        start_at(10'h3FF);
        nop();
        chk("wrap_up", 32'(ProgCtr), 32'h000);
        br(0, 1, 2, 0);
        br(0, 1, 6'b111000, 0);     // 2 - 8
        chk("wrap_down", 32'(ProgCtr), 32'h3FA);

        // Ack beats branch, halt holds, restart clears counter
        br(0, 1, 18, 0);            // 0x3FA + 18 -> 12
        br(0, 1, 5, 1);
        chk("halt_pc", 32'(ProgCtr), 32'd12);
        chk("halt_done", 32'(Done), 32'd1);
        nop();
        nop();
        start_at(0);
        chk("restart_cnt", 32'(CycleCount), 32'd0);

        // reset mid-run wipes the LUT
        br(0, 1, 31, 0);
        br(0, 1, 9, 0);
        chk("pc40", 32'(ProgCtr), 32'd40);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        start_at(0);
        br(1, 1, 3, 0);
        chk("lut_cleared", 32'(ProgCtr), 32'd0);

        // counter saturation
        repeat (65540) nop();
        chk("cnt_sat", 32'(CycleCount), 32'hFFFF);

        // randomized traffic
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 1023)), 1'($urandom), 1'($urandom),
                 1'($urandom), int'($urandom_range(0, 63)),
                 $urandom_range(0, 15) == 0, 1'($urandom),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 1023)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
